// File: rtl/mw_load_store_unit.sv
// Memory/writeback-stage load/store unit for the 3-stage RV32I pipeline.
// Issues one req/ack data-memory access per load/store, formats load data,
// picks writeback data and freezes the MW stage while an access is in flight.
module mw_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  InstF_MW_opcode,
  input  logic [2:0]  InstF_MW_funct3,
  input  logic [1:0]  wb_selMW,
  input  logic        reg_wrMW,
  input  logic [31:0] alu_resultMW,
  input  logic [31:0] rs2_dataMW,
  input  logic [31:0] pc_plus4MW,
  input  logic [31:0] csr_rdataMW,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  output logic        Stall_MW,
  output logic [31:0] wb_data,
  output logic        reg_wr_en,
  output logic        lsu_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  logic [1:0]      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wmask_q, wmask_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     load_q, load_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic            tmo_q, tmo_d;

  logic            is_load, is_store, f3_legal, aligned, issue_ok;
  logic [31:0]     fmt_data;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [CntW-1:0] cnt_inc;
  logic            stall_c, reg_wr_c, err_c;
  logic [31:0]     wb_c;

  // Decode legality and alignment of the MW-stage instruction.
  always_comb begin
    is_load  = (InstF_MW_opcode == OpLoad);
    is_store = (InstF_MW_opcode == OpStore);
    f3_legal = 1'b0;
    if (is_load) begin
      f3_legal = (InstF_MW_funct3 == 3'b000) || (InstF_MW_funct3 == 3'b001) ||
                 (InstF_MW_funct3 == 3'b010) || (InstF_MW_funct3 == 3'b100) ||
                 (InstF_MW_funct3 == 3'b101);
    end else if (is_store) begin
      f3_legal = (InstF_MW_funct3 == 3'b000) || (InstF_MW_funct3 == 3'b001) ||
                 (InstF_MW_funct3 == 3'b010);
    end
    case (InstF_MW_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~alu_resultMW[0];
      2'b10:   aligned = (alu_resultMW[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    issue_ok = (is_load || is_store) && f3_legal && aligned;
  end

  // Extract and extend the addressed lane of the returned word.
  always_comb begin
    byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
    half_sel = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  fmt_data = {24'd0, byte_sel};
      3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  fmt_data = {16'd0, half_sel};
      3'b010:  fmt_data = dmem_rdata;
      default: fmt_data = 32'd0;
    endcase
  end

  // FSM next state, bus register updates and per-state control outputs.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    tmo_d    = tmo_q;
    stall_c  = 1'b0;
    reg_wr_c = 1'b0;
    err_c    = 1'b0;
    cnt_inc  = cnt_q + 1'b1;
    case (state_q)
      StIdle: begin
        if (is_load || is_store) begin
          if (issue_ok) begin
            stall_c  = 1'b1;
            req_d    = 1'b1;
            we_d     = is_store;
            addr_d   = {alu_resultMW[31:2], 2'b00};
            funct3_d = InstF_MW_funct3;
            off_d    = alu_resultMW[1:0];
            cnt_d    = '0;
            tmo_d    = 1'b0;
            load_d   = 32'd0;
            wmask_d  = 4'b0000;
            wdata_d  = 32'd0;
            if (is_store) begin
              case (InstF_MW_funct3[1:0])
                2'b00: begin
                  wmask_d = 4'b0001 << alu_resultMW[1:0];
                  wdata_d = {4{rs2_dataMW[7:0]}};
                end
                2'b01: begin
                  wmask_d = 4'b0011 << {alu_resultMW[1], 1'b0};
                  wdata_d = {2{rs2_dataMW[15:0]}};
                end
                default: begin
                  wmask_d = 4'b1111;
                  wdata_d = rs2_dataMW;
                end
              endcase
            end
            state_d = StWait;
          end else begin
            err_c = 1'b1;
          end
        end else begin
          reg_wr_c = reg_wrMW;
        end
      end
      StWait: begin
        stall_c = 1'b1;
        if (dmem_ack) begin
          load_d  = we_q ? 32'd0 : fmt_data;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
          load_d  = 32'd0;
          req_d   = 1'b0;
          cnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        reg_wr_c = reg_wrMW & ~we_q & ~tmo_q;
        err_c    = tmo_q;
        tmo_d    = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Writeback source select; load data is only meaningful in DONE.
  always_comb begin
    case (wb_selMW)
      2'b00:   wb_c = alu_resultMW;
      2'b01:   wb_c = (state_q == StDone) ? load_q : 32'd0;
      2'b10:   wb_c = pc_plus4MW;
      default: wb_c = csr_rdataMW;
    endcase
  end

  // State and bus registers; reset drops any outstanding request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wmask_q  <= 4'b0000;
      cnt_q    <= '0;
      load_q   <= 32'd0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      tmo_q    <= tmo_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  always_comb begin
    dmem_req   = req_q;
    dmem_we    = we_q;
    dmem_addr  = addr_q;
    dmem_wdata = wdata_q;
    dmem_wmask = wmask_q;
    Stall_MW   = stall_c & ~rst;
    reg_wr_en  = reg_wr_c & ~rst;
    lsu_err    = err_c & ~rst;
    wb_data    = rst ? 32'd0 : wb_c;
  end

endmodule

// File: tb/tb_mw_load_store_unit.sv
// Randomized self-checking bench for mw_load_store_unit against a
// transaction-level reference model.
module tb_mw_load_store_unit;

  localparam int unsigned T = 16;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  wb_sel;
  logic        reg_wr;
  logic [31:0] alu_res, rs2, pc4, csr;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we, stall, reg_wr_en, lsu_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_wmask;

  int n_cmp = 0;
  int n_err = 0;

  mw_load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .InstF_MW_opcode(opcode),
    .InstF_MW_funct3(funct3),
    .wb_selMW       (wb_sel),
    .reg_wrMW       (reg_wr),
    .alu_resultMW   (alu_res),
    .rs2_dataMW     (rs2),
    .pc_plus4MW     (pc4),
    .csr_rdataMW    (csr),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wmask     (dmem_wmask),
    .Stall_MW       (stall),
    .wb_data        (wb_data),
    .reg_wr_en      (reg_wr_en),
    .lsu_err        (lsu_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == OP_LOAD)  return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    if (op == OP_STORE) return f3 inside {3'b000, 3'b001, 3'b010};
    return 1'b0;
  endfunction

  function automatic bit ref_aligned(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    sz = 32'(f3) % 4;
    if (sz == 0) return 1'b1;
    if (sz == 1) return (a % 2) == 0;
    if (sz == 2) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned o, b, h;
    o = a % 4;
    b = (rd >> (8 * o)) & 32'hFF;
    h = (rd >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b101:  return h;
      3'b010:  return rd;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wmask(input logic [2:0] f3, input logic [31:0] a);
    int unsigned o;
    o = a % 4;
    if (f3 == 3'b000) return 32'd1 << o;
    if (f3 == 3'b001) return 32'd3 << ((o / 2) * 2);
    return 32'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'b000) return (d & 32'hFF) * 32'h01010101;
    if (f3 == 3'b001) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_mux(input logic [1:0] s, input logic [31:0] ld);
    case (s)
      2'b00:   return alu_res;
      2'b01:   return ld;
      2'b10:   return pc4;
      default: return csr;
    endcase
  endfunction

  // One MW-stage instruction from IDLE back to IDLE. ack_at: WAIT cycle index
  // of the ack, or -1 for a memory that never answers.
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] s,
                         input logic rw, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int ack_at);
    bit is_mem, is_ld, legal, timed_out;
    int waits;
    logic [31:0] ld;
    @(negedge clk);
    opcode = op; funct3 = f3; wb_sel = s; reg_wr = rw; alu_res = a; rs2 = d;
    pc4 = $urandom; csr = $urandom;
    dmem_ack = 1'($urandom % 2);
    dmem_rdata = $urandom;
    #1;
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
    is_ld  = (op == OP_LOAD);
    legal  = ref_legal(op, f3) && ref_aligned(f3, a);
    if (!is_mem) begin
      check_eq("op_stall", 32'(stall), 32'd0);
      check_eq("op_req", 32'(dmem_req), 32'd0);
      check_eq("op_regwr", 32'(reg_wr_en), 32'(rw));
      check_eq("op_err", 32'(lsu_err), 32'd0);
      check_eq("op_wb", wb_data, ref_mux(s, 32'd0));
      return;
    end
    if (!legal) begin
      check_eq("bad_stall", 32'(stall), 32'd0);
      check_eq("bad_req", 32'(dmem_req), 32'd0);
      check_eq("bad_err", 32'(lsu_err), 32'd1);
      check_eq("bad_regwr", 32'(reg_wr_en), 32'd0);
      return;
    end
    check_eq("iss_stall", 32'(stall), 32'd1);
    check_eq("iss_req", 32'(dmem_req), 32'd0);
    check_eq("iss_regwr", 32'(reg_wr_en), 32'd0);
    check_eq("iss_err", 32'(lsu_err), 32'd0);
    waits = (ack_at < 0) ? int'(T) : ack_at + 1;
    for (int k = 0; k < waits; k++) begin
      @(negedge clk);
      dmem_ack = (k == ack_at);
      dmem_rdata = (k == ack_at) ? rd : $urandom;
      #1;
      check_eq("w_req", 32'(dmem_req), 32'd1);
      check_eq("w_we", 32'(dmem_we), 32'(!is_ld));
      check_eq("w_addr", dmem_addr, {a[31:2], 2'b00});
      check_eq("w_mask", 32'(dmem_wmask), is_ld ? 32'd0 : ref_wmask(f3, a));
      if (!is_ld) check_eq("w_wdata", dmem_wdata, ref_wdata(f3, d));
      check_eq("w_stall", 32'(stall), 32'd1);
      check_eq("w_regwr", 32'(reg_wr_en), 32'd0);
      check_eq("w_err", 32'(lsu_err), 32'd0);
    end
    @(negedge clk);
    dmem_ack = 1'($urandom % 2);
    dmem_rdata = $urandom;
    #1;
    timed_out = (ack_at < 0);
    ld = (is_ld && !timed_out) ? ref_load(f3, a, rd) : 32'd0;
    check_eq("d_req", 32'(dmem_req), 32'd0);
    check_eq("d_stall", 32'(stall), 32'd0);
    check_eq("d_regwr", 32'(reg_wr_en), 32'(rw && is_ld && !timed_out));
    check_eq("d_err", 32'(lsu_err), 32'(timed_out));
    check_eq("d_wb", wb_data, ref_mux(s, ld));
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r, ack_at;
    rst = 1'b1;
    opcode = OP_ALU; funct3 = 3'b000; wb_sel = 2'b00; reg_wr = 1'b1;
    alu_res = 32'h1234_5678; rs2 = 32'h0; pc4 = 32'h4; csr = 32'h9;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #2;
    check_eq("rst_req", 32'(dmem_req), 32'd0);
    check_eq("rst_we", 32'(dmem_we), 32'd0);
    check_eq("rst_addr", dmem_addr, 32'd0);
    check_eq("rst_wdata", dmem_wdata, 32'd0);
    check_eq("rst_mask", 32'(dmem_wmask), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_regwr", 32'(reg_wr_en), 32'd0);
    check_eq("rst_err", 32'(lsu_err), 32'd0);
    check_eq("rst_wb", wb_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_txn(OP_LOAD,  3'b010, 2'b01, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    run_txn(OP_LOAD,  3'b000, 2'b01, 1'b1, 32'h103, 32'h0, 32'h80123456, 0);
    run_txn(OP_LOAD,  3'b100, 2'b01, 1'b1, 32'h103, 32'h0, 32'h80123456, 1);
    run_txn(OP_LOAD,  3'b101, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80123456, 2);
    run_txn(OP_STORE, 3'b001, 2'b00, 1'b0, 32'h102, 32'h00001234, 32'h0, 0);
    run_txn(OP_LOAD,  3'b010, 2'b01, 1'b1, 32'h101, 32'h0, 32'h0, 0);
    run_txn(OP_ALU,   3'b000, 2'b10, 1'b1, 32'h55, 32'h0, 32'h0, 0);
    run_txn(OP_LOAD,  3'b010, 2'b01, 1'b1, 32'h200, 32'h0, 32'h0, -1);
    run_txn(OP_LOAD,  3'b001, 2'b01, 1'b1, 32'h206, 32'h0, 32'hCAFEF00D, int'(T) - 1);

    // Reset in the middle of WAIT.
    @(negedge clk);
    opcode = OP_LOAD; funct3 = 3'b010; wb_sel = 2'b01; reg_wr = 1'b1;
    alu_res = 32'h100; dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    check_eq("mr_req_before", 32'(dmem_req), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mr_req", 32'(dmem_req), 32'd0);
    check_eq("mr_stall", 32'(stall), 32'd0);
    check_eq("mr_wb", wb_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    opcode = OP_ALU; wb_sel = 2'b00; reg_wr = 1'b1; alu_res = 32'hA5A5_0001;
    dmem_ack = 1'b1;
    #1;
    check_eq("mr_idle_stall", 32'(stall), 32'd0);
    check_eq("mr_idle_regwr", 32'(reg_wr_en), 32'd1);
    check_eq("mr_idle_wb", wb_data, 32'hA5A5_0001);
    @(negedge clk);
    #1;
    check_eq("mr_ack_ignored", 32'(dmem_req), 32'd0);
    check_eq("mr_ack_stall", 32'(stall), 32'd0);
    run_txn(OP_LOAD, 3'b010, 2'b01, 1'b1, 32'h300, 32'h0, 32'h0BAD_F00D, 0);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom % 8);
      if (r < 3)      op = OP_LOAD;
      else if (r < 6) op = OP_STORE;
      else            op = (r == 6) ? OP_ALU : 7'b0010011;
      f3 = 3'($urandom);
      a = $urandom;
      if ($urandom % 4 != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      r = int'($urandom % 10);
      if (r < 7)       ack_at = int'($urandom % 4);
      else if (r == 7) ack_at = int'(T) - 1;
      else if (r == 8) ack_at = -1;
      else             ack_at = int'($urandom % 8);
      run_txn(op, f3, 2'($urandom), 1'($urandom), a, $urandom, $urandom, ack_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
